qam_symbol_packer: RTL
======================

QAM_SYMBOL_PACKER -- requirements
Module: qam_symbol_packer

Interface
REQ-001 Parameter N, default 16: number of parallel symbols per output word.
REQ-002 Parameter B, default 3: bits per symbol (3 for the 8-point mapper).
REQ-003 Parameter IW, default 8: input beat width in bits; B*N SHALL be an integer multiple of IW, with elaboration failing otherwise.
REQ-004 Derived constants OW = B*N (48 at defaults) and BEATS = OW/IW (6 at defaults).
REQ-005 clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 rst, input, 1: reset, synchronous and active-high.
REQ-007 in_data, input, IW: raw bit-stream beat.
REQ-008 in_valid, input, 1: in_data is valid.
REQ-009 in_last, input, 1: this beat ends the frame.
REQ-010 in_ready, output, 1: packer accepts a beat this cycle.
REQ-011 out_data, output, OW: clustered word; bits [B*i+B-1:B*i] form symbol i and feed the mapper's `in` directly.
REQ-012 out_valid, output, 1: out_data is valid.
REQ-013 out_last, output, 1: word closes a frame.
REQ-014 out_ready, input, 1: downstream accepts the word.

Function
REQ-015 A beat SHALL be accepted exactly when in_valid && in_ready.
REQ-016 Output handshake: transfer when out_valid && out_ready; out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-017 in_ready SHALL equal !(out_valid && !out_ready), combinational; no other dependence.
REQ-018 Packing order: the k-th accepted beat of a word (k = 0..BEATS-1) SHALL occupy accumulator bits [IW*k+IW-1:IW*k], so the first beat lands in the LSBs.
REQ-019 Beat counter cnt: range 0..BEATS-1; increments on each accepted beat; wraps to 0 when a word completes.
REQ-020 A word completes on an accepted beat with cnt == BEATS-1, or on any accepted beat with in_last=1.
REQ-021 On completion, in that same edge: the accumulator with the completing beat merged in SHALL load into out_data; out_valid is set; out_last = in_last; cnt and accumulator clear to 0.
REQ-022 Latency: out_valid SHALL be high in the cycle after the completing beat is accepted.
REQ-023 On early completion via in_last, unfilled upper bits SHALL be 0.
REQ-024 A completing beat together with in_last on cnt == BEATS-1 SHALL produce a single word with out_last=1 and no extra empty word.
REQ-025 If a completion and an output transfer occur in the same cycle, out_valid SHALL stay 1 with the new word loaded. This gives full throughput: one word per BEATS cycles with no bubbles.
REQ-026 If an output transfer occurs without a completion, out_valid SHALL clear.
REQ-027 A non-completing accepted beat SHALL NOT alter out_data, out_valid or out_last.
REQ-028 No beat is ever dropped or duplicated. While stalled, in_ready=0 and the accumulator and cnt hold.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set: out_valid=0, out_last=0, out_data=0, cnt=0, accumulator=0.
REQ-030 A reset mid-word SHALL discard the partial word, with no output produced for it.
REQ-031 A reset while out_valid=1 SHALL drop the pending word.
REQ-032 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-033 Shared package qam_pkg SHALL hold N, B, IW defaults and the derived OW and BEATS; the mapper and packer both import it.
REQ-034 Single module with no sub-module. The output register stage is inline: one accumulator, one counter, and one output register.

Verification
REQ-035 Beats 0x01..0x06, each accepted, with out_ready=1 -> one cycle after beat 6: out_data=48'h060504030201, out_valid=1, out_last=0.
REQ-036 Beats 0xAA, 0x55 with in_last=1 on 0x55 -> out_data=48'h00000000_55AA, out_last=1; the next frame starts at cnt=0.
REQ-037 12 back-to-back beats 0x00..0x0B with out_ready=1 -> in_ready stays 1 throughout, producing words 48'h050403020100 then 48'h0B0A09080706.
REQ-038 First word held with out_ready=0 while the second word's beats arrive -> in_ready=0 during the stall; out_data is unchanged; both words are delivered intact and in order after out_ready=1.
REQ-039 rst asserted after 3 beats, then 6 beats 0x10..0x15 -> only 48'h151413121110 is output.
REQ-040 Random in_valid/out_ready for 10k beats against a reference model -> exact bit-order match, and out_last on every frame end.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared sizing for the QAM mapper datapath: symbol count, symbol width and
// the packer's input beat width, plus the derived word and beat counts.
package qam_pkg;

    localparam int unsigned QAM_N     = 16;
    localparam int unsigned QAM_B     = 3;
    localparam int unsigned QAM_IW    = 8;
    localparam int unsigned QAM_OW    = QAM_B * QAM_N;
    localparam int unsigned QAM_BEATS = QAM_OW / QAM_IW;

    // Counter width that still yields one bit when only a single beat exists.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/qam_symbol_packer.sv
// Packs IW-bit stream beats, LSB first, into B*N-bit symbol words for the
// mapper; a frame end flushes a partial word with zero-filled upper bits.
module qam_symbol_packer
    import qam_pkg::*;
#(
    parameter int unsigned N  = QAM_N,
    parameter int unsigned B  = QAM_B,
    parameter int unsigned IW = QAM_IW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [B*N-1:0]  out_data,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready
);

    localparam int unsigned OW    = B * N;
    localparam int unsigned BEATS = OW / IW;
    localparam int unsigned CW    = cnt_width(BEATS);

    generate
        if ((OW % IW) != 0) begin : g_bad_width
            $error("qam_symbol_packer: B*N must be a multiple of IW");
        end
    endgenerate

    logic [OW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [31:0]   sh;
    logic [OW-1:0] merged;
    logic          accept;
    logic          complete;

    // Accepting is only possible when the output slot is empty or draining,
    // so a completing beat can always overwrite the output register.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt == CW'(BEATS - 1)));

    always_comb begin
        sh     = 32'(cnt) * IW;
        merged = acc | (OW'(in_data) << sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (complete) begin
                out_data <= merged;
                out_last <= in_last;
                acc      <= '0;
                cnt      <= '0;
            end else if (accept) begin
                acc <= merged;
                cnt <= cnt + 1'b1;
            end

            if (complete)
                out_valid <= 1'b1;
            else if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
